// File: rtl/coin_pkg.sv
// Coin codes and conditioner state encoding, shared with the vending FSM.
package coin_pkg;

    localparam int unsigned COIN_W = 2;

    typedef enum logic [COIN_W-1:0] {
        COIN_NONE     = 2'b00,
        COIN_CIRCLE   = 2'b01,
        COIN_TRIANGLE = 2'b10,
        COIN_PENTAGON = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        DEB_PRESS = 2'b01,
        HELD      = 2'b10,
        DEB_REL   = 2'b11
    } cond_state_t;

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Board-side inputs and conditioned coin events between the board and the vending FSM.
interface coin_input_conditioner_if #(
    parameter int unsigned COUNT_W = 8
);
    import coin_pkg::*;

    logic                  insert_n;
    logic [COIN_W-1:0]     coin_sel;
    logic                  drop;
    coin_t                 coin;
    logic                  coin_valid;
    logic                  rejected;
    logic                  busy;
    logic [COUNT_W-1:0]    accepted_count;

    modport master (
        output insert_n, coin_sel, drop,
        input  coin, coin_valid, rejected, busy, accepted_count
    );

    modport slave (
        input  insert_n, coin_sel, drop,
        output coin, coin_valid, rejected, busy, accepted_count
    );

endinterface

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for asynchronous board inputs, with a configurable reset value.
module input_synchronizer #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages come out of reset at the idle value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces the insert key and turns each physical press into one coin or reject pulse.
module coin_input_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    coin_input_conditioner_if.slave  cif
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               insert_n_sync;
    logic [COIN_W-1:0]  sel_sync;
    logic               press;

    cond_state_t        state;
    logic [CNT_W-1:0]   cnt;
    coin_t              coin_q;
    logic               valid_q;
    logic               rej_q;
    logic               busy_q;
    logic [COUNT_W-1:0] count_q;

    input_synchronizer #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_insert_sync (
        .clock (clock),
        .reset (reset),
        .din   (cif.insert_n),
        .dout  (insert_n_sync)
    );

    input_synchronizer #(
        .WIDTH     (COIN_W),
        .RESET_VAL (COIN_W'(COIN_NONE))
    ) u_sel_sync (
        .clock (clock),
        .reset (reset),
        .din   (cif.coin_sel),
        .dout  (sel_sync)
    );

    assign press = ~insert_n_sync;

    // Debounce FSM; coming out of reset in HELD forces a release before the next press counts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= HELD;
            cnt     <= '0;
            coin_q  <= COIN_NONE;
            valid_q <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b1;
            count_q <= '0;
        end else begin
            coin_q  <= COIN_NONE;
            valid_q <= 1'b0;
            rej_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (press) begin
                        state  <= DEB_PRESS;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!press) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        if ((coin_t'(sel_sync) != COIN_NONE) && !cif.drop) begin
                            coin_q  <= coin_t'(sel_sync);
                            valid_q <= 1'b1;
                            count_q <= count_q + COUNT_W'(1);
                        end else begin
                            rej_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!press) begin
                        state <= DEB_REL;
                        cnt   <= '0;
                    end
                end
                DEB_REL: begin
                    if (press) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= HELD;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign cif.coin           = coin_q;
    assign cif.coin_valid     = valid_q;
    assign cif.rejected       = rej_q;
    assign cif.busy           = busy_q;
    assign cif.accepted_count = count_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed and randomized bench for coin_input_conditioner with a run-length debounce model.
module tb_coin_input_conditioner;
    import coin_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    coin_input_conditioner_if #(.COUNT_W(CW)) bus ();

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .COUNT_W         (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .cif   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;
    int valid_seen = 0;
    int rej_seen = 0;
    int wraps = 0;
    int valid_edge = -1;
    logic [1:0]    last_coin = 2'b00;
    logic [CW-1:0] prev_cnt = '0;
    bit rand_mode = 1'b0;

    // Model: two-sample input delay, then a debounced level that flips only after
    // DEB+1 consecutive synced samples disagree with it.
    logic       m_s1, m_s2;
    logic [1:0] m_sel1, m_sel2;
    logic       m_lvl;
    int         m_run;
    logic [1:0] exp_coin;
    logic       exp_valid, exp_rej;
    int         exp_cnt;

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_sel1 = 2'b00; m_sel2 = 2'b00;
        m_lvl = 1'b1; m_run = 0;
        exp_coin = 2'b00; exp_valid = 1'b0; exp_rej = 1'b0; exp_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic exp_busy;
        exp_busy = (m_lvl == 1'b0 && m_run == 0) ? 1'b0 : 1'b1;
        chk("coin", 32'(bus.coin), 32'(exp_coin));
        chk("coin_valid", 32'(bus.coin_valid), 32'(exp_valid));
        chk("rejected", 32'(bus.rejected), 32'(exp_rej));
        chk("accepted_count", 32'(bus.accepted_count), 32'(exp_cnt));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        chk("valid_and_rej", 32'(bus.coin_valid & bus.rejected), 32'd0);
    endtask

    task automatic step();
        logic       p;
        logic [1:0] sel;
        @(posedge clock);
        edge_no++;
        if (!reset) begin
            p   = ~m_s2;
            sel = m_sel2;
            m_s2 = m_s1;     m_s1 = bus.insert_n;
            m_sel2 = m_sel1; m_sel1 = bus.coin_sel;
            exp_coin = 2'b00; exp_valid = 1'b0; exp_rej = 1'b0;
            if (p != m_lvl) begin
                m_run++;
                if (m_run == int'(DEB) + 1) begin
                    m_lvl = p;
                    m_run = 0;
                    if (p) begin
                        if (sel != 2'b00 && !bus.drop) begin
                            exp_coin  = sel;
                            exp_valid = 1'b1;
                            exp_cnt   = (exp_cnt + 1) % (1 << CW);
                        end else begin
                            exp_rej = 1'b1;
                        end
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        @(negedge clock);
        check_all();
        if (bus.coin_valid === 1'b1) begin
            valid_seen++;
            last_coin = bus.coin;
            if (valid_edge < 0) valid_edge = edge_no;
        end
        if (bus.rejected === 1'b1) rej_seen++;
        if (prev_cnt == CW'(255) && bus.accepted_count == CW'(0)) wraps++;
        prev_cnt = bus.accepted_count;
        if (rand_mode) begin
            bus.drop     = 1'($urandom_range(0, 1));
            bus.coin_sel = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic hold(input logic key_n, input int n);
        bus.insert_n = key_n;
        repeat (n) step();
    endtask

    task automatic clear_tallies();
        valid_seen = 0; rej_seen = 0; valid_edge = -1;
    endtask

    initial begin
        int k;
        bus.insert_n = 1'b1;
        bus.coin_sel = 2'b00;
        bus.drop     = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        reset = 1'b0;
        hold(1'b1, 8);

        // 1: clean insert and latency
        clear_tallies();
        bus.coin_sel = 2'b01;
        k = edge_no + 1;
        hold(1'b0, 12);
        hold(1'b1, 10);
        chk("t1_latency", 32'(valid_edge - k), 32'(DEB + 2));
        chk("t1_pulses", 32'(valid_seen), 32'd1);
        chk("t1_coin", 32'(last_coin), 32'h1);

        // 2: bouncy press
        clear_tallies();
        bus.coin_sel = 2'b11;
        hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 10);
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 10);
        chk("t2_pulses", 32'(valid_seen), 32'd1);
        chk("t2_coin", 32'(last_coin), 32'h3);

        // 3: empty select
        clear_tallies();
        bus.coin_sel = 2'b00;
        hold(1'b0, 10); hold(1'b1, 10);
        chk("t3_rej", 32'(rej_seen), 32'd1);
        chk("t3_valid", 32'(valid_seen), 32'd0);

        // 4: lockout then accept
        clear_tallies();
        bus.coin_sel = 2'b10;
        bus.drop = 1'b1;
        hold(1'b0, 10);
        bus.drop = 1'b0;
        hold(1'b1, 10);
        chk("t4_rej", 32'(rej_seen), 32'd1);
        chk("t4_valid_locked", 32'(valid_seen), 32'd0);
        hold(1'b0, 10); hold(1'b1, 10);
        chk("t4_valid", 32'(valid_seen), 32'd1);
        chk("t4_coin", 32'(last_coin), 32'h2);

        // 5: reset two cycles into debounce, key held through reset
        clear_tallies();
        bus.coin_sel = 2'b01;
        hold(1'b0, 4);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        reset = 1'b0;
        hold(1'b0, 15);
        chk("t5_no_pulse", 32'(valid_seen + rej_seen), 32'd0);
        hold(1'b1, 10);
        hold(1'b0, 10); hold(1'b1, 10);
        chk("t5_after", 32'(valid_seen), 32'd1);

        // 6: counter wrap
        clear_tallies();
        wraps = 0;
        bus.coin_sel = 2'b01;
        for (int i = 0; i < 256; i++) begin
            hold(1'b0, 7);
            hold(1'b1, 8);
        end
        chk("t6_valid", 32'(valid_seen), 32'd256);
        chk("t6_wraps", 32'(wraps), 32'd1);

        // random presses with bounce, random select and drop each cycle
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                hold(1'b0, $urandom_range(1, 3));
                hold(1'b1, $urandom_range(1, 2));
            end
            hold(1'b0, $urandom_range(2, 12));
            repeat ($urandom_range(0, 2)) begin
                hold(1'b1, $urandom_range(1, 3));
                hold(1'b0, $urandom_range(1, 2));
            end
            hold(1'b1, $urandom_range(3, 10));
        end
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
